prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//   Multi-target program loader; successor to the single-target testbench loader.
//   Accepts a valid/ready word stream (addr, data, last) from the bench or a debug
//   bridge and steers each word to one of NUM_TGT memories (IMEM, DMEM, ...).
//   Holds the core in reset while loading and releases it only after a clean load.
//   Sits between the host interface and the memories' write ports in Top.
// PARAMETERS
//   ADDR_W    32                          byte-address width
//   DATA_W    32                          word width (power of 2 bytes, >= 8)
//   NUM_TGT   2                           number of target memories
//   TGT_BASE  {32'h8010_0000,32'h8000_0000}  packed NUM_TGT*ADDR_W region bases; tgt0 in LSBs
//   TGT_AW    16                          log2 region size in bytes (all regions equal)
//   CNT_W     16                          width of word counter
// PORTS
//   clk        in   1               clock, all logic on posedge
//   rst        in   1               synchronous, active-high reset
//   load_start in   1               pulse: begin a load session
//   ld_valid   in   1               stream word valid
//   ld_ready   out  1               loader accepts word this cycle
//   ld_addr    in   ADDR_W          byte address of word
//   ld_data    in   DATA_W          word data
//   ld_last    in   1               final word of session
//   mem_we     out  NUM_TGT         one-hot write strobe per target
//   mem_waddr  out  TGT_AW          byte offset within selected region
//   mem_wdata  out  DATA_W          write data
//   cpu_rst    out  1               core reset; high while not RUN
//   done       out  1               session completed without error
//   err        out  1               sticky: unmapped or misaligned word seen
//   err_addr   out  ADDR_W          address of first offending word
//   word_cnt   out  CNT_W           words written this session (saturating)
//   csum       out  DATA_W          running checksum (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE; ld_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_rst=1,
//     done=0, err=0, err_addr=0, word_cnt=0, csum=0. An in-flight write is dropped.
//   States: IDLE, LOAD, RELEASE, RUN. All outputs are registered or decoded from state.
//   IDLE: cpu_rst=1. load_start -> LOAD; clear word_cnt, err, err_addr, csum, done.
//   LOAD: ld_ready=1. Handshake = ld_valid & ld_ready. On handshake at edge N:
//     - hit = lowest i with ld_addr[ADDR_W-1:TGT_AW]==TGT_BASE_i[ADDR_W-1:TGT_AW]
//       and ld_addr low log2(DATA_W/8) bits == 0. Overlapping regions: lowest i wins.
//     - hit: in cycle N+1, mem_we[i]=1 for exactly one cycle,
//       mem_waddr=ld_addr[TGT_AW-1:0], mem_wdata=ld_data; word_cnt+=1, saturating at all-ones.
//     - miss or misaligned: no write; err<=1; err_addr captured only if err was 0.
//     - ld_last on handshake -> RELEASE. load_start is ignored in LOAD and RELEASE.
//   RELEASE (1 cycle): ld_ready=0; final write commits. Next state: RUN if err==0,
//     else IDLE (cpu_rst stays 1, done stays 0).
//   RUN: cpu_rst=0, done=1. load_start -> LOAD; cpu_rst=1 and done=0 from the next cycle.
//   mem_we is 0 in every cycle without a preceding hit handshake. mem_waddr/mem_wdata
//     hold their last values when mem_we=0.
//   Back-to-back handshakes sustain 1 word/cycle; no write-port backpressure.
//   ld_valid with ld_ready=0 (IDLE/RELEASE/RUN) is ignored; no state change.
// CONFIGURATION
//   PROG_LOADER_CSUM_EN defined: csum <= csum + ld_data (mod 2^DATA_W) on every
//     handshake, including rejected words; cleared on load_start; held in RUN.
//   Undefined: csum port is still present and is tied to 0; no adder is built.
// TESTING
//   1. Reset, start, 4 words at 0x8000_0000..0x8000_000C, last on 4th -> mem_we=2'b01
//      x4, waddr 0,4,8,C; RELEASE 1 cycle; RUN: cpu_rst=0, done=1, word_cnt=4.
//   2. Word to 0x8010_0020 -> mem_we=2'b10, mem_waddr=0x0020, 1 cycle after handshake.
//   3. Words to 0x9000_0000 then 0x8000_0002, last -> no mem_we; err=1,
//      err_addr=0x9000_0000; RELEASE -> IDLE; cpu_rst=1, done=0.
//   4. rst asserted the cycle after a hit handshake -> mem_we=0 next cycle; all outputs
//      at reset values.
//   5. In RUN, pulse load_start -> cpu_rst=1 next cycle, word_cnt=0; a new 2-word load
//      ending in last -> RUN again.
//   6. CSUM_EN: data 0xFFFF_FFFF, 0x0000_0002 -> csum=0x0000_0001. Without: csum=0.

Source files
------------

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Multi-target program loader. Accepts a valid/ready word
//               stream and steers each word to one of NUM_TGT memory write
//               ports. Holds the core in reset while loading and releases it
//               only after a load that saw no unmapped or misaligned word.
//               Optional feature macro: PROG_LOADER_CSUM_EN (running checksum
//               of every accepted word; csum is tied to 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_TGT = 2,
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE = {32'h8010_0000, 32'h8000_0000},
  parameter int TGT_AW  = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic               ld_last,
  output logic [NUM_TGT-1:0] mem_we,
  output logic [TGT_AW-1:0]  mem_waddr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [CNT_W-1:0]   word_cnt,
  output logic [DATA_W-1:0]  csum
);

  localparam int LSB_W = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_ld_ready;
  logic                 w_cpu_rst;
  logic                 w_done;
  logic                 w_hs;
  logic                 w_start;
  logic                 w_aligned;
  logic                 w_found;
  logic                 w_hit;
  logic [NUM_TGT-1:0]   w_hit_vec;

  logic [NUM_TGT-1:0]   r_mem_we;
  logic [TGT_AW-1:0]    r_mem_waddr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic                 r_err;
  logic [ADDR_W-1:0]    r_err_addr;
  logic [CNT_W-1:0]     r_word_cnt;

  // A word is only accepted while loading; load_start only acts when not loading
  assign w_hs    = ld_valid & (r_state == LOAD);
  assign w_start = load_start & ((r_state == IDLE) || (r_state == RUN));

  // Word alignment check; byte-wide words are always aligned
  generate
    if (LSB_W == 0) begin : g_align_byte
      assign w_aligned = 1'b1;
    end else begin : g_align_word
      assign w_aligned = (ld_addr[LSB_W-1:0] == '0);
    end
  endgenerate

  // Region decode: lowest-numbered matching target wins on overlap
  always_comb begin
    w_hit_vec = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (!w_found &&
          (ld_addr[ADDR_W-1:TGT_AW] == TGT_BASE[i*ADDR_W+TGT_AW +: ADDR_W-TGT_AW])) begin
        w_hit_vec[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  assign w_hit = w_found & w_aligned;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next     = r_state;
    w_ld_ready = 1'b0;
    w_cpu_rst  = 1'b1;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_start) w_next = LOAD;
      end
      LOAD: begin
        w_ld_ready = 1'b1;
        if (w_hs && ld_last) w_next = RELEASE;
      end
      RELEASE: begin
        // Error flag already includes the final word at this point
        w_next = r_err ? IDLE : RUN;
      end
      RUN: begin
        w_cpu_rst = 1'b0;
        w_done    = 1'b1;
        if (load_start) w_next = LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  // Write port, error capture and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= '0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_mem_we <= '0;
      if (w_start) begin
        r_err      <= 1'b0;
        r_err_addr <= '0;
        r_word_cnt <= '0;
      end else if (w_hs) begin
        if (w_hit) begin
          r_mem_we    <= w_hit_vec;
          r_mem_waddr <= ld_addr[TGT_AW-1:0];
          r_mem_wdata <= ld_data;
          if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + 1'b1;
        end else begin
          r_err <= 1'b1;
          if (!r_err) r_err_addr <= ld_addr;
        end
      end
    end
  end

`ifdef PROG_LOADER_CSUM_EN
  logic [DATA_W-1:0] r_csum;

  // Checksum over every accepted word, including rejected ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum + ld_data;
    end
  end

  assign csum = r_csum;
`else
  assign csum = '0;
`endif

  assign ld_ready  = w_ld_ready;
  assign cpu_rst   = w_cpu_rst;
  assign done      = w_done;
  assign mem_we    = r_mem_we;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;
  assign err_addr  = r_err_addr;
  assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Stimulus pushes expected
//               memory writes into a queue; a monitor pops and compares each
//               write the DUT presents. Status outputs are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic [1:0]  mem_we;
  logic [15:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [31:0] err_addr;
  logic [15:0] word_cnt;
  logic [31:0] csum;

  typedef struct packed {
    logic [1:0]  we;
    logic [15:0] waddr;
    logic [31:0] wdata;
  } wr_t;

  wr_t  exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] exp_csum;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr),
    .word_cnt   (word_cnt),
    .csum       (csum)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (mem_we !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_write: got we=%b waddr=0x%0h wdata=0x%0h, expected none",
                 mem_we, mem_waddr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_we",    {62'd0, mem_we},    {62'd0, e.we});
        chk("wr_waddr", {48'd0, mem_waddr}, {48'd0, e.waddr});
        chk("wr_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    exp_csum   = 32'd0;
    tick();
    load_start = 1'b0;
  endtask

  // Present one word; it is accepted at the next edge
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic last,
                      input logic [1:0] exp_we);
    wr_t e;
    chk("ld_ready_in_load", {63'd0, ld_ready}, 64'd1);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    exp_csum = exp_csum + d;
    if (exp_we != 2'b00) begin
      e.we    = exp_we;
      e.waddr = a[15:0];
      e.wdata = d;
      exp_q.push_back(e);
    end
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic crst,
                            input logic dn, input logic er, input logic [15:0] cnt);
    chk({tag, "_ld_ready"}, {63'd0, ld_ready}, {63'd0, rdy});
    chk({tag, "_cpu_rst"},  {63'd0, cpu_rst},  {63'd0, crst});
    chk({tag, "_done"},     {63'd0, done},     {63'd0, dn});
    chk({tag, "_err"},      {63'd0, err},      {63'd0, er});
    chk({tag, "_word_cnt"}, {48'd0, word_cnt}, {48'd0, cnt});
  endtask

  task automatic chk_csum(input string tag);
`ifdef PROG_LOADER_CSUM_EN
    chk({tag, "_csum"}, {32'd0, csum}, {32'd0, exp_csum});
`else
    chk({tag, "_csum"}, {32'd0, csum}, 64'd0);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_status(tag, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk({tag, "_mem_we"},    {62'd0, mem_we},    64'd0);
    chk({tag, "_mem_waddr"}, {48'd0, mem_waddr}, 64'd0);
    chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    chk({tag, "_err_addr"},  {32'd0, err_addr},  64'd0);
    chk({tag, "_csum"},      {32'd0, csum},      64'd0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0;
    ld_addr = '0; ld_data = '0; ld_last = 1'b0; exp_csum = '0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Stream word while IDLE is ignored
    ld_valid = 1'b1; ld_addr = 32'h8000_0000; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk_status("idle_ignore", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    // Test 1: four words to region 0, back to back
    start();
    chk_status("load1", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send(32'h8000_0000, 32'h1111_0000, 1'b0, 2'b01);
    send(32'h8000_0004, 32'h2222_0001, 1'b0, 2'b01);
    send(32'h8000_0008, 32'h3333_0002, 1'b0, 2'b01);
    send(32'h8000_000C, 32'h4444_0003, 1'b1, 2'b01);
    chk_status("release1", 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    tick();
    chk_status("run1", 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
    chk_csum("run1");
    tick();
    chk_status("run1_hold", 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);

    // Tests 5 and 2: restart from RUN, write to region 1 then region 0
    start();
    chk_status("restart", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send(32'h8010_0020, 32'hA5A5_5A5A, 1'b0, 2'b10);
    send(32'h8000_0010, 32'h0BAD_F00D, 1'b1, 2'b01);
    tick();
    chk_status("run2", 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    chk_csum("run2");

    // Test 6: checksum wraps modulo 2^32
    start();
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2'b01);
    send(32'h8000_0004, 32'h0000_0002, 1'b1, 2'b01);
    tick();
    chk_status("run3", 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
`ifdef PROG_LOADER_CSUM_EN
    chk("csum_wrap", {32'd0, csum}, 64'h0000_0001);
`else
    chk("csum_off", {32'd0, csum}, 64'd0);
`endif

    // Test 3: unmapped then misaligned word; failed load returns to IDLE
    start();
    send(32'h9000_0000, 32'h1234_5678, 1'b0, 2'b00);
    chk("err_after_unmapped", {63'd0, err}, 64'd1);
    send(32'h8000_0002, 32'h0000_0010, 1'b1, 2'b00);
    chk_status("release_err", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
    chk("err_addr_first", {32'd0, err_addr}, 64'h9000_0000);
    chk_csum("release_err");
    tick();
    chk_status("idle_after_err", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
    tick();
    chk("still_idle_cpu_rst", {63'd0, cpu_rst}, 64'd1);

    // Test 4: reset right after a hit handshake
    start();
    chk("err_cleared_on_start", {63'd0, err}, 64'd0);
    send(32'h8000_0008, 32'hCAFE_0004, 1'b0, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("post_rst");
    tick();
    chk("post_rst_we", {62'd0, mem_we}, 64'd0);

    repeat (2) tick();
    chk("queue_empty", {32'd0, exp_q.size()}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
